// File: rtl/hwpf_pkg.sv
// Shared types and constants for the next-line hardware prefetch issue controller.
package hwpf_pkg;

  localparam int unsigned HWPF_ADDR_W      = 32;
  localparam int unsigned HWPF_PAGE_SIZE   = 4096;
  localparam int unsigned HWPF_PAGE_BITS   = $clog2(HWPF_PAGE_SIZE);
  localparam int unsigned HWPF_DEDUP_DEPTH = 4;
  localparam int unsigned HWPF_CNT_W       = 16;

  typedef logic [HWPF_ADDR_W-1:0] hwpf_addr_t;

  typedef enum logic {
    HWPF_IDLE  = 1'b0,
    HWPF_ISSUE = 1'b1
  } hwpf_state_t;

  // Clear the byte-offset bits of an address for a power-of-two line size.
  function automatic hwpf_addr_t hwpf_line_align(input hwpf_addr_t addr,
                                                 input int unsigned lane_size);
    return addr & ~(HWPF_ADDR_W'(lane_size) - HWPF_ADDR_W'(1));
  endfunction

endpackage

// File: rtl/hwpf_dedup_filter.sv
// Small FIFO of recently accepted prefetch line addresses with a parallel match.
// Instantiated by hwpf_issue_ctrl only when HWPF_DEDUP_EN is defined.
module hwpf_dedup_filter
  import hwpf_pkg::*;
#(
  parameter type addr_t = hwpf_addr_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  push,
  input  addr_t push_addr,
  input  addr_t lookup_addr,
  output logic  hit
);

  localparam int unsigned PTR_W = $clog2(HWPF_DEDUP_DEPTH);

  addr_t                       entry_q [HWPF_DEDUP_DEPTH];
  logic [HWPF_DEDUP_DEPTH-1:0] vld_q;
  logic [PTR_W-1:0]            ptr_q;

  // Entry payloads need no reset; the valid bits gate every match.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      vld_q <= '0;
      ptr_q <= '0;
    end else if (push) begin
      entry_q[ptr_q] <= push_addr;
      vld_q[ptr_q]   <= 1'b1;
      ptr_q          <= ptr_q + PTR_W'(1);
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < int'(HWPF_DEDUP_DEPTH); i++) begin
      if (vld_q[i] && (entry_q[i] == lookup_addr)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/hwpf_issue_ctrl.sv
// Pops a trigger address from the prefetch stack and issues up to DEGREE next-line
// requests within the same 4 KiB page. Optional duplicate filter: HWPF_DEDUP_EN.
module hwpf_issue_ctrl
  import hwpf_pkg::*;
#(
  parameter int unsigned LANE_SIZE  = 64,
  parameter int unsigned DEGREE     = 2,
  parameter type         cpu_addr_t = hwpf_addr_t
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  flush_i,
  input  logic                  stack_valid_i,
  input  cpu_addr_t             stack_addr_i,
  output logic                  stack_pop_o,
  output logic                  stack_lock_o,
  output logic                  stack_flush_o,
  input  logic                  cpu_busy_i,
  output logic                  pf_req_valid_o,
  input  logic                  pf_req_ready_i,
  output cpu_addr_t             pf_req_addr_o,
  output logic                  busy_o,
  output logic [HWPF_CNT_W-1:0] issued_cnt_o
);

  localparam int unsigned ADDR_W    = $bits(cpu_addr_t);
  localparam int unsigned IDX_W     = $clog2(DEGREE + 1);
  localparam int unsigned LANE_BITS = $clog2(LANE_SIZE);

  hwpf_state_t           state_q, state_d;
  cpu_addr_t             base_q, base_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  held_q, held_d;
  logic                  flush_q, flush_d;
  logic [HWPF_CNT_W-1:0] issued_cnt_q;

  cpu_addr_t cand;
  logic      in_page;
  logic      last;
  logic      dup_hit;
  logic      pop;
  logic      valid;
  logic      hs;

  assign cand    = base_q + (cpu_addr_t'(idx_q) << LANE_BITS);
  assign in_page = (cand[ADDR_W-1:HWPF_PAGE_BITS] == base_q[ADDR_W-1:HWPF_PAGE_BITS]);
  assign last    = (idx_q == IDX_W'(DEGREE));

`ifdef HWPF_DEDUP_EN
  hwpf_dedup_filter #(
    .addr_t(cpu_addr_t)
  ) u_dedup (
    .clk        (clk_i),
    .rst        (rst_i),
    .clear      (flush_i),
    .push       (hs),
    .push_addr  (cand),
    .lookup_addr(cand),
    .hit        (dup_hit)
  );
`else
  assign dup_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= HWPF_IDLE;
      base_q       <= '0;
      idx_q        <= '0;
      held_q       <= 1'b0;
      flush_q      <= 1'b0;
      issued_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      held_q  <= held_d;
      flush_q <= flush_d;
      if (hs && (issued_cnt_q != '1)) issued_cnt_q <= issued_cnt_q + HWPF_CNT_W'(1);
    end
  end

  // A held request ignores cpu_busy_i and flush_i until its handshake completes.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    held_d  = held_q;
    flush_d = flush_q;
    pop     = 1'b0;
    valid   = 1'b0;
    hs      = 1'b0;
    case (state_q)
      HWPF_IDLE: begin
        held_d  = 1'b0;
        flush_d = 1'b0;
        if (enable_i && stack_valid_i && !flush_i) begin
          pop     = 1'b1;
          base_d  = cpu_addr_t'(hwpf_line_align(hwpf_addr_t'(stack_addr_i), LANE_SIZE));
          idx_d   = IDX_W'(1);
          state_d = HWPF_ISSUE;
        end
      end
      HWPF_ISSUE: begin
        if (held_q) begin
          valid = 1'b1;
        end else if (!in_page || flush_i) begin
          state_d = HWPF_IDLE;
        end else if (dup_hit) begin
          if (last) state_d = HWPF_IDLE;
          else      idx_d   = idx_q + IDX_W'(1);
        end else if (!cpu_busy_i) begin
          valid = 1'b1;
        end
        if (valid) begin
          if (pf_req_ready_i) begin
            hs     = 1'b1;
            held_d = 1'b0;
            if (last || flush_i || flush_q) state_d = HWPF_IDLE;
            else                            idx_d   = idx_q + IDX_W'(1);
          end else begin
            held_d  = 1'b1;
            flush_d = flush_q | flush_i;
          end
        end
      end
      default: state_d = HWPF_IDLE;
    endcase
  end

  assign stack_pop_o    = pop & ~rst_i;
  assign stack_lock_o   = ~enable_i;
  assign stack_flush_o  = flush_i;
  assign pf_req_valid_o = valid & ~rst_i;
  assign pf_req_addr_o  = pf_req_valid_o ? cand : '0;
  assign busy_o         = (state_q == HWPF_ISSUE) & ~rst_i;
  assign issued_cnt_o   = issued_cnt_q;

endmodule

// File: doc/hwpf_issue_ctrl.md
HWPF_ISSUE_CTRL -- requirements
Module: hwpf_issue_ctrl

Interface
REQ-001 SHALL use clock clk_i and reset rst_i; one clock domain; reset is synchronous and active-high.
REQ-002 SHALL have parameter LANE_SIZE, default 64, cache line size in bytes (power of two).
REQ-003 SHALL have parameter DEGREE, default 2, next lines issued per trigger (1..8).
REQ-004 SHALL have parameter cpu_addr_t, default the dcache io_base_addr width, address type.
REQ-005 SHALL have the following ports (name  direction  width  meaning):
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- enable_i  in  1  prefetcher enable.
- flush_i  in  1  flush request.
- stack_valid_i  in  1  stack has an entry.
- stack_addr_i  in  cpu_addr_t  stack top address.
- stack_pop_o  out  1  pop stack top.
- stack_lock_o  out  1  freeze stack.
- stack_flush_o  out  1  flush stack.
- cpu_busy_i  in  1  demand access owns the dcache port this cycle.
- pf_req_valid_o  out  1  prefetch request valid.
- pf_req_ready_i  in  1  dcache accepts the request.
- pf_req_addr_o  out  cpu_addr_t  line-aligned prefetch address.
- busy_o  out  1  FSM not IDLE.
- issued_cnt_o  out  16  accepted-request count.

Function
REQ-006 SHALL implement FSM states IDLE and ISSUE.
REQ-007 IDLE: when enable_i & stack_valid_i & !flush_i, SHALL assert stack_pop_o combinationally for one cycle, latch base = stack_addr_i & ~(LANE_SIZE-1), set idx=1 and go to ISSUE.
REQ-008 Pop-to-first-request latency SHALL be 1 cycle.
REQ-009 ISSUE: the candidate address SHALL be base + idx*LANE_SIZE, computed modulo the cpu_addr_t width.
REQ-010 SHALL drop the candidate and all remaining lines and return to IDLE, without asserting valid, when the candidate lies in a different 4 KiB page than base.
REQ-011 cpu_busy_i SHALL block only the new assertion of pf_req_valid_o.
REQ-012 Once pf_req_valid_o is asserted, it and pf_req_addr_o SHALL stay stable until pf_req_ready_i.
REQ-013 On handshake: if idx==DEGREE, SHALL go to IDLE; else SHALL increment idx.
REQ-014 Back-to-back requests are allowed, one per cycle.
REQ-015 flush_i SHALL drive stack_flush_o the same cycle.
REQ-016 flush_i with no pending valid: SHALL go to IDLE next cycle.
REQ-017 flush_i while valid is pending: SHALL complete that handshake, then go to IDLE, dropping the remaining lines.
REQ-018 A flush arriving in IDLE SHALL suppress that cycle's pop.
REQ-019 stack_lock_o SHALL equal !enable_i; the FSM SHALL not pop while enable_i is low.
REQ-020 Deasserting enable_i during ISSUE SHALL finish the current trigger.
REQ-021 issued_cnt_o SHALL increment on each handshake and saturate at 0xFFFF.
REQ-022 issued_cnt_o SHALL be cleared only by reset; flush SHALL not clear it.
REQ-023 busy_o SHALL be 1 whenever the state is ISSUE.

Reset
REQ-024 While rst_i is high: state IDLE, idx 0, base 0, issued_cnt_o 0.
REQ-025 While rst_i is high: stack_pop_o, pf_req_valid_o and busy_o are 0; pf_req_addr_o is 0.
REQ-026 While rst_i is high: stack_flush_o follows flush_i; stack_lock_o follows !enable_i.
REQ-027 Reset asserted mid-request SHALL abandon it without waiting for ready.

Configuration
REQ-028 With HWPF_DEDUP_EN defined: a 4-entry FIFO SHALL hold the last accepted line addresses.
REQ-029 With HWPF_DEDUP_EN defined: a candidate matching any valid FIFO entry SHALL be skipped with no request, one cycle per skip, advancing idx or finishing as in REQ-013.
REQ-030 With HWPF_DEDUP_EN defined: the FIFO SHALL be cleared by reset and flush.
REQ-031 Without HWPF_DEDUP_EN: no filter logic is present, and every in-page candidate SHALL be issued.

Structure
REQ-032 Package hwpf_pkg SHALL hold the hwpf_state_t enum, HWPF_PAGE_SIZE=4096, HWPF_DEDUP_DEPTH=4 and the line-align function.
REQ-033 The dedup filter SHALL be the sub-module hwpf_dedup_filter, instantiated only under HWPF_DEDUP_EN.

Verification
REQ-034 LANE_SIZE=64, DEGREE=2, stack_addr_i=0x1010, ready tied 1 -> pop in cycle 0; requests 0x1040 (cycle 1) and 0x1080 (cycle 2); issued_cnt_o=2.
REQ-035 stack_addr_i=0x1F80 -> request 0x1FC0; 0x2000 is dropped; IDLE; issued_cnt_o=1.
REQ-036 ready low 3 cycles with cpu_busy_i toggling after valid -> valid and addr 0x1040 held stable through all stall cycles.
REQ-037 flush_i during a stalled request 0x1040 -> stack_flush_o=1; after ready, no 0x1080; IDLE; counter +1.
REQ-038 HWPF_DEDUP_EN, triggers 0x1000 then 0x1040 -> requests 0x1040, 0x1080, then 0x10C0 only (0x1080 skipped).
REQ-039 Counter preset near max (force 0xFFFE), 3 handshakes -> issued_cnt_o=0xFFFF; rst_i mid-request -> all outputs at reset values next cycle.
